// File: rtl/ab_gate_pipe_if.sv
// Producer/consumer bus of the A/B gate pipeline: input operands, function
// select and accumulator clear in, result and its population count out.
interface ab_gate_pipe_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Handshake: a transfer happens on a rising clk edge where valid & ready
    // are both high. valid, once raised, holds with stable payload until that
    // edge. ready may depend combinationally on the far side's ready.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [1:0]       mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic [CNT_W-1:0] z_ones;

    modport master (
        output in_valid, x, y, mode, acc_clr, out_ready,
        input  in_ready, out_valid, z, z_ones
    );

    modport slave (
        input  in_valid, x, y, mode, acc_clr, out_ready,
        output in_ready, out_valid, z, z_ones
    );
endinterface

// File: rtl/ab_gate_pipe.sv
// Two-stage valid/ready pipeline evaluating the A/B gate network bitwise,
// with mode select, running-XOR accumulator and result popcount.
module ab_gate_pipe #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          areset_n,
    ab_gate_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] MODE_CLASSIC = 2'd0;
    localparam logic [1:0] MODE_ASYM    = 2'd1;
    localparam logic [1:0] MODE_EQUAL   = 2'd2;
    localparam logic [1:0] MODE_ACCUM   = 2'd3;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic [1:0]       s1_mode;
    logic             s2_valid;
    logic [WIDTH-1:0] z_q;
    logic [CNT_W-1:0] ones_q;
    logic [WIDTH-1:0] acc;

    logic             s2_free;
    logic             s1_adv;
    logic             in_hs;
    logic [WIDTH-1:0] a_xy;
    logic [WIDTH-1:0] a_yx;
    logic [WIDTH-1:0] b_xy;
    logic [WIDTH-1:0] classic;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] z_next;
    logic [CNT_W-1:0] ones_next;

    assign s2_free      = !s2_valid || bus.out_ready;
    assign s1_adv       = s1_valid && s2_free;
    assign bus.in_ready = !s1_valid || s2_free;
    assign in_hs        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = s2_valid;
    assign bus.z         = z_q;
    assign bus.z_ones    = ones_q;

    // Gates written out literally; classic still folds to x | ~y in synthesis.
    assign a_xy    = s1_x & ~s1_y;
    assign a_yx    = s1_y & ~s1_x;
    assign b_xy    = ~(s1_x ^ s1_y);
    assign classic = (a_xy | b_xy) ^ (a_xy & b_xy);
    assign acc_eff = bus.acc_clr ? '0 : acc;

    always_comb begin
        z_next = classic;
        case (s1_mode)
            MODE_CLASSIC: z_next = classic;
            MODE_ASYM:    z_next = a_xy ^ a_yx;
            MODE_EQUAL:   z_next = b_xy;
            MODE_ACCUM:   z_next = acc_eff ^ classic;
            default:      z_next = classic;
        endcase
    end

    always_comb begin
        ones_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_next = ones_next + CNT_W'(z_next[i]);
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_mode  <= MODE_CLASSIC;
        end else begin
            s1_valid <= in_hs || (s1_valid && !s1_adv);
            if (in_hs) begin
                s1_x    <= bus.x;
                s1_y    <= bus.y;
                s1_mode <= bus.mode;
            end
        end
    end

    // Output registers change only on an advance, so bubbles keep the last result.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            s2_valid <= 1'b0;
            z_q      <= '0;
            ones_q   <= '0;
        end else begin
            s2_valid <= s1_adv || (s2_valid && !bus.out_ready);
            if (s1_adv) begin
                z_q    <= z_next;
                ones_q <= ones_next;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            acc <= '0;
        end else if (s1_adv && s1_mode == MODE_ACCUM) begin
            acc <= z_next;
        end else if (bus.acc_clr) begin
            acc <= '0;
        end
    end
endmodule

// File: tb/tb_ab_gate_pipe.sv
// Directed bench for ab_gate_pipe: latency, modes, throughput, backpressure,
// accumulator behaviour and asynchronous reset, with an in-order scoreboard.
module tb_ab_gate_pipe;
    logic clk;
    logic areset_n;
    int   n_vec;
    int   n_err;
    int   waits;
    logic [11:0] exp_q[$];

    ab_gate_pipe_if #(.WIDTH(8)) bus ();

    ab_gate_pipe #(.WIDTH(8)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction, waits (bounded) for acceptance, queues its expected result.
    task automatic drive(input logic [1:0] m, input logic [7:0] xv, input logic [7:0] yv,
                         input logic [7:0] ez, input logic [3:0] eo, output int w);
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.y        = yv;
        bus.mode     = m;
        w            = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            w++;
            @(posedge clk);
            #1;
        end
        if (w >= 40) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            exp_q.push_back({ez, eo});
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard: every output transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (areset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("sb_z", 64'(bus.z), 64'(e[11:4]));
                check("sb_ones", 64'(bus.z_ones), 64'(e[3:0]));
            end
        end
    end

    typedef struct {
        logic [1:0] m;
        logic [7:0] xv;
        logic [7:0] yv;
        logic [7:0] ez;
        logic [3:0] eo;
    } vec_t;

    vec_t mode_vecs[3];
    vec_t b2b_vecs[4];
    vec_t acc_vecs[3];

    initial begin
        n_vec = 0;
        n_err = 0;
        mode_vecs[0] = '{2'd0, 8'hA5, 8'h3C, 8'hE7, 4'd6};
        mode_vecs[1] = '{2'd1, 8'hA5, 8'h3C, 8'h99, 4'd4};
        mode_vecs[2] = '{2'd2, 8'hA5, 8'h3C, 8'h66, 4'd4};
        b2b_vecs[0]  = '{2'd0, 8'h00, 8'hFF, 8'h00, 4'd0};
        b2b_vecs[1]  = '{2'd0, 8'hFF, 8'hFF, 8'hFF, 4'd8};
        b2b_vecs[2]  = '{2'd0, 8'h0F, 8'hFF, 8'h0F, 4'd4};
        b2b_vecs[3]  = '{2'd0, 8'hF0, 8'hFF, 8'hF0, 4'd4};
        acc_vecs[0]  = '{2'd3, 8'hA5, 8'h3C, 8'hE7, 4'd6};
        acc_vecs[1]  = '{2'd3, 8'hA5, 8'h3C, 8'h00, 4'd0};
        acc_vecs[2]  = '{2'd3, 8'hA5, 8'h3C, 8'hE7, 4'd6};

        areset_n      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.mode      = '0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        areset_n = 1'b1;
        step();

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_z", 64'(bus.z), 64'd0);
        check("rst_ones", 64'(bus.z_ones), 64'd0);

        // Each mode in isolation, with exact two-cycle latency
        foreach (mode_vecs[i]) begin
            drive(mode_vecs[i].m, mode_vecs[i].xv, mode_vecs[i].yv, mode_vecs[i].ez, mode_vecs[i].eo, waits);
            check("lat_1cyc_valid", 64'(bus.out_valid), 64'd0);
            step();
            check("lat_2cyc_valid", 64'(bus.out_valid), 64'd1);
            check("mode_z", 64'(bus.z), 64'(mode_vecs[i].ez));
            check("mode_ones", 64'(bus.z_ones), 64'(mode_vecs[i].eo));
            step();
            check("bubble_valid", 64'(bus.out_valid), 64'd0);
            check("bubble_hold_z", 64'(bus.z), 64'(mode_vecs[i].ez));
        end

        // Back-to-back at full throughput
        foreach (b2b_vecs[i]) begin
            drive(b2b_vecs[i].m, b2b_vecs[i].xv, b2b_vecs[i].yv, b2b_vecs[i].ez, b2b_vecs[i].eo, waits);
            check("b2b_no_wait", 64'(waits), 64'd0);
        end
        check("b2b_first_out", 64'(bus.z), 64'h0F);
        step();
        step();
        step();
        check("b2b_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: two accepts, then in_ready drops and z holds
        bus.out_ready = 1'b0;
        drive(2'd0, 8'h0F, 8'hFF, 8'h0F, 4'd4, waits);
        check("bp_accept1", 64'(waits), 64'd0);
        drive(2'd0, 8'hF0, 8'hFF, 8'hF0, 4'd4, waits);
        check("bp_accept2", 64'(waits), 64'd0);
        bus.in_valid = 1'b1;
        bus.x        = 8'h3C;
        bus.y        = 8'h3C;
        bus.mode     = 2'd1;
        for (int k = 0; k < 4; k++) begin
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("bp_valid_held", 64'(bus.out_valid), 64'd1);
            check("bp_z_stable", 64'(bus.z), 64'h0F);
            check("bp_ones_stable", 64'(bus.z_ones), 64'd4);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        drive(2'd1, 8'h3C, 8'h3C, 8'h00, 4'd0, waits);
        for (int k = 0; k < 4; k++) step();
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Accumulator: acc starts at 0 after reset
        foreach (acc_vecs[i]) begin
            drive(acc_vecs[i].m, acc_vecs[i].xv, acc_vecs[i].yv, acc_vecs[i].ez, acc_vecs[i].eo, waits);
        end
        for (int k = 0; k < 3; k++) step();

        // acc_clr alone (acc was E7), then mode 3 must give plain classic
        bus.acc_clr = 1'b1;
        step();
        bus.acc_clr = 1'b0;
        drive(2'd3, 8'hA5, 8'h3C, 8'hE7, 4'd6, waits);
        for (int k = 0; k < 3; k++) step();

        // acc_clr on the advance cycle of a mode-3 input (acc is E7 here)
        drive(2'd3, 8'hA5, 8'h3C, 8'hE7, 4'd6, waits);
        bus.acc_clr = 1'b1;
        step();
        bus.acc_clr = 1'b0;
        check("clr_adv_z", 64'(bus.z), 64'hE7);
        for (int k = 0; k < 3; k++) step();
        check("acc_drained", 64'(exp_q.size()), 64'd0);

        // Async reset mid-stall; acc is E7, so a stale acc would show as z=00 afterwards
        bus.out_ready = 1'b0;
        drive(2'd0, 8'hA5, 8'h3C, 8'hE7, 4'd6, waits);
        step();
        check("stall_pre_rst_z", 64'(bus.z), 64'hE7);
        #2;
        areset_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_z", 64'(bus.z), 64'd0);
        check("arst_ones", 64'(bus.z_ones), 64'd0);
        exp_q.delete();
        step();
        areset_n      = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        drive(2'd3, 8'hA5, 8'h3C, 8'hE7, 4'd6, waits);
        step();
        check("post_rst_valid", 64'(bus.out_valid), 64'd1);
        check("post_rst_acc_z", 64'(bus.z), 64'hE7);
        for (int k = 0; k < 3; k++) step();
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
